adder_arbiter: RTL and testbench
================================

Name: adder_arbiter

Overview:
- Shares one instance of the team's 32-bit combinational `adder` between two requesters, e.g. the PC-increment path and the branch-target path.
- Arbitration is round-robin with valid/ready handshakes on both the request and response sides.
- The sum is registered and held until the owning requester accepts it.
- At most one operation is in flight; a new one may be accepted in the same cycle the previous response retires.

Parameters:
- WIDTH, 32, operand/result width passed to the adder instance.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req0_valid  input  1  requester 0 has operands.
- req0_ready  output  1  requester 0 accepted this cycle when high with valid.
- req0_a  input  WIDTH  requester 0 operand a.
- req0_b  input  WIDTH  requester 0 operand b.
- req1_valid  input  1  requester 1 has operands.
- req1_ready  output  1  requester 1 accept.
- req1_a  input  WIDTH  requester 1 operand a.
- req1_b  input  WIDTH  requester 1 operand b.
- resp0_valid  output  1  result on resp_data belongs to requester 0.
- resp0_ready  input  1  requester 0 takes result.
- resp1_valid  output  1  result belongs to requester 1.
- resp1_ready  input  1  requester 1 takes result.
- resp_data  output  WIDTH  registered sum.
- busy  output  1  high while a result is held (state RESP).
- op_count  output  CNTW  number of completed response handshakes.

Behaviour:
- One clock, clk. rst is asynchronous and active-high; all state clears immediately on assertion.
- Reset values:
  - state=IDLE, last_grant=1, owner=0.
  - resp_data=0, resp0_valid=resp1_valid=0, busy=0, op_count=0.
- States: IDLE (no result held), RESP (result held for owner).
- Arbitration (combinational, every cycle):
  - Only one valid: that requester is the winner.
  - Both valid: winner is the requester not equal to last_grant. After reset, requester 0 wins the first tie.
  - None valid: no winner.
- Accept window: `accept_ok = (state==IDLE) | (state==RESP & resp handshake of owner this cycle)`.
- Ready: reqN_ready = (winner==N) & accept_ok. The losing requester's ready is 0. Ready is never asserted without its valid.
- Acceptance (reqN_valid & reqN_ready), on the next edge:
  - resp_data <= reqN_a + reqN_b, computed by the adder instance; truncated mod 2^WIDTH, carry discarded.
  - owner <= N, last_grant <= N, state <= RESP.
- Latency: response valid the cycle after acceptance, i.e. one cycle.
- RESP state:
  - resp<owner>_valid=1; the other resp valid is 0.
  - resp_data and owner are held stable until resp<owner>_ready=1.
  - Ready on the non-owner response port is ignored.
- Response handshake: op_count increments by 1, wrapping from 2^CNTW-1 to 0.
  - No simultaneous acceptance: state <= IDLE and resp valids deassert next cycle.
  - Simultaneous acceptance (back-to-back): state stays RESP, resp_data/owner load the new operation, and the appropriate valid is high next cycle with no bubble.
- Operands must be held stable while valid & !ready. Violations are not checked.
- X/Z operands are passed through the adder unfiltered. No X-checking in RTL.
- Reset mid-operation: held result is discarded, valids drop asynchronously, and op_count clears.

Test Plan:
- Reset then single request:
  - Stimulus: req0 a=32'h12345678, b=32'h00000001, resp0_ready=1.
  - Response: req0_ready=1 in the same cycle. Next cycle resp0_valid=1, resp_data=32'h12345679, busy=1, resp1_valid=0. Then IDLE; op_count=1.
- Overflow wrap:
  - Stimulus: req1 a=32'hFFFFFFFF, b=32'h00000002.
  - Response: resp1_valid with resp_data=32'h00000001.
- Tie and round-robin:
  - Stimulus: both valid every cycle (req0 5+6, req1 7+8), both resp_ready=1.
  - Response: grants alternate 0,1,0,1 with no bubble cycles. resp_data sequence 11,15,11,15. op_count advances by 1 per cycle.
- Backpressure:
  - Stimulus: req0 3+4 accepted; resp0_ready=0 for 3 cycles while req1_valid=1.
  - Response: resp_data=7 held, req1_ready=0 throughout. When resp0_ready=1, req1 is accepted in that same cycle and its result appears the next cycle.
- Wrong-port ready:
  - Stimulus: owner=0, resp1_ready=1, resp0_ready=0.
  - Response: state stays RESP; op_count unchanged.
- Async reset mid-RESP:
  - Stimulus: assert rst between clock edges while a result is held.
  - Response: resp valids, busy and op_count go to 0 immediately. After release, the first tie grants requester 0.

Source files
------------

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one combinational adder between two valid/ready requesters
// Ports: clk/rst (async active-high); req0_*/req1_* operand channels (valid, ready, a, b);
// resp0_valid/resp1_valid + resp0_ready/resp1_ready own the shared registered resp_data;
// busy is high while a result is held; op_count counts completed response handshakes.
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);
    assign sum = a + b;
endmodule

module adder_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             busy,
    output logic [CNTW-1:0]  op_count
);
    typedef enum logic {IDLE, RESP} state_t;
    state_t           state;
    logic             last_grant;
    logic             owner;
    logic             win;
    logic             win_any;
    logic             resp_hs;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum;
    // On a tie the requester that did not win last time goes next.
    always_comb begin
        win_any    = req0_valid | req1_valid;
        win        = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
        resp_hs    = (resp0_valid & resp0_ready) | (resp1_valid & resp1_ready);
        accept     = win_any & ((state == IDLE) | resp_hs);
        req0_ready = accept & ~win;
        req1_ready = accept & win;
        op_a       = win ? req1_a : req0_a;
        op_b       = win ? req1_b : req0_b;
    end
    adder #(.WIDTH(WIDTH)) u_adder (.a(op_a), .b(op_b), .sum(sum));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            resp_data   <= '0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            busy        <= 1'b0;
            op_count    <= '0;
        end else begin
            if (resp_hs)
                op_count <= op_count + 1'b1;
            // A new acceptance takes priority so back-to-back operations leave no bubble.
            if (accept) begin
                state       <= RESP;
                resp_data   <= sum;
                owner       <= win;
                last_grant  <= win;
                resp0_valid <= ~win;
                resp1_valid <= win;
                busy        <= 1'b1;
            end else if (resp_hs) begin
                state       <= IDLE;
                resp0_valid <= 1'b0;
                resp1_valid <= 1'b0;
                busy        <= 1'b0;
            end
        end
    end
    logic unused_owner;
    assign unused_owner = owner;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed scoreboard bench for adder_arbiter
module tb_adder_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [31:0] resp_data;
    logic        busy;
    logic [15:0] op_count;
    typedef struct {
        logic        own;
        logic [31:0] data;
    } exp_t;
    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] cnt = '0;
    logic        lg = 1'b1;

    adder_arbiter #(.WIDTH(32), .CNTW(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_data(resp_data), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks the DUT at the falling edge against the model, then advances the model
    // to what the coming rising edge should do.
    task automatic step();
        logic e0, e1, ehs, w, any, ok, er0, er1;
        exp_t n;
        @(negedge clk);
        e0  = (q.size() > 0) && (q[0].own == 1'b0);
        e1  = (q.size() > 0) && (q[0].own == 1'b1);
        ck("resp0_valid", resp0_valid, e0);
        ck("resp1_valid", resp1_valid, e1);
        ck("busy", busy, q.size() > 0);
        ck("op_count", op_count, cnt);
        if (q.size() > 0) ck("resp_data", resp_data, q[0].data);
        ehs = (e0 & resp0_ready) | (e1 & resp1_ready);
        any = req0_valid | req1_valid;
        w   = (req0_valid & req1_valid) ? ~lg : req1_valid;
        ok  = (q.size() == 0) || ehs;
        er0 = any & ok & ~w;
        er1 = any & ok & w;
        ck("req0_ready", req0_ready, er0);
        ck("req1_ready", req1_ready, er1);
        if (ehs) begin
            void'(q.pop_front());
            cnt = cnt + 16'd1;
        end
        if (er0 | er1) begin
            n.own  = w;
            n.data = w ? req1_a + req1_b : req0_a + req0_b;
            q.push_back(n);
            lg = w;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        ck("rst resp_data", resp_data, 32'h0);
        ck("rst busy", busy, 1'b0);
        ck("rst op_count", op_count, 16'h0);
        ck("rst valids", {resp0_valid, resp1_valid}, 2'b00);
        @(posedge clk);
        #1 rst = 1'b0;
        // single request
        req0_valid = 1; req0_a = 32'h12345678; req0_b = 32'h00000001; resp0_ready = 1;
        step();
        req0_valid = 0;
        step();
        step();
        ck("single op_count", op_count, 16'd1);
        // overflow wrap
        req1_valid = 1; req1_a = 32'hFFFFFFFF; req1_b = 32'h00000002; resp1_ready = 1;
        step();
        req1_valid = 0;
        ck("wrap data", resp_data, 32'h00000001);
        step();
        step();
        // tie and round-robin, back-to-back
        req0_valid = 1; req0_a = 5; req0_b = 6;
        req1_valid = 1; req1_a = 7; req1_b = 8;
        repeat (5) step();
        req0_valid = 0; req1_valid = 0;
        repeat (2) step();
        // backpressure
        resp0_ready = 0; resp1_ready = 0;
        req0_valid = 1; req0_a = 3; req0_b = 4;
        step();
        req0_valid = 0;
        req1_valid = 1; req1_a = 9; req1_b = 10;
        repeat (3) step();
        ck("bp held data", resp_data, 32'd7);
        resp0_ready = 1;
        step();
        req1_valid = 0; resp1_ready = 1;
        step();
        step();
        // wrong-port ready
        resp0_ready = 0; resp1_ready = 1;
        req0_valid = 1; req0_a = 1; req0_b = 1;
        step();
        req0_valid = 0;
        repeat (2) step();
        // asynchronous reset while a result is held
        #2 rst = 1'b1;
        #1;
        ck("arst valids", {resp0_valid, resp1_valid}, 2'b00);
        ck("arst busy", busy, 1'b0);
        ck("arst op_count", op_count, 16'h0);
        q.delete();
        cnt = '0;
        lg = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        req0_valid = 1; req0_a = 5; req0_b = 6;
        req1_valid = 1; req1_a = 7; req1_b = 8;
        resp0_ready = 1; resp1_ready = 1;
        step();
        req0_valid = 0; req1_valid = 0;
        ck("post-reset owner0", resp0_valid, 1'b1);
        repeat (3) step();
        ck("scoreboard drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
